// File: rtl/command_fifo_interface.sv
`timescale 1ns/1ps
`default_nettype none
//=============================================================================
// Module   : command_fifo_interface
// Purpose  : Host command port for the GPU. Synchronises the asynchronous
//            host controls into commandClk, buffers host writes (command plus
//            data) in a first-word-fall-through FIFO for the GPU core, and runs
//            a read-request state machine that fetches a data word from the
//            GPU and drives it back toward the host pads.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
// Ports:
//   commandClk     in   GPU clock, all logic on rising edge
//   resetN         in   asynchronous active-low reset
//   chipSelect     in   host chip select (async)
//   outputEnable   in   host read enable (async)
//   writeStrobe    in   host write strobe (async), rising edge commits a write
//   inputCommand   in   host command pins
//   dataIn         in   host data pins, write direction
//   dataOut        out  host data pins, read direction
//   dataOutEnable  out  pad tristate enable for dataOut
//   commandToGpu   out  FIFO head command (0 when empty)
//   dataToGpu      out  FIFO head data (0 when empty)
//   cmdValid       out  FIFO not empty
//   cmdReady       in   GPU takes head entry when cmdValid && cmdReady
//   fifoCount      out  FIFO occupancy
//   busy           out  FIFO full
//   overflow       out  sticky, a host write was dropped
//   readReq        out  one-cycle read request to the GPU
//   readData       in   GPU read data
//   readValid      in   readData valid this cycle
//   readTimeout    out  sticky, a read timed out
//   clearFlags     in   clears overflow and readTimeout
//=============================================================================
module command_fifo_interface #(
   parameter int unsigned CMD_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned READ_TIMEOUT = 64
) (
   input  logic                         commandClk,
   input  logic                         resetN,
   input  logic                         chipSelect,
   input  logic                         outputEnable,
   input  logic                         writeStrobe,
   input  logic [CMD_WIDTH-1:0]         inputCommand,
   input  logic [DATA_WIDTH-1:0]        dataIn,
   output logic [DATA_WIDTH-1:0]        dataOut,
   output logic                         dataOutEnable,
   output logic [CMD_WIDTH-1:0]         commandToGpu,
   output logic [DATA_WIDTH-1:0]        dataToGpu,
   output logic                         cmdValid,
   input  logic                         cmdReady,
   output logic [$clog2(DEPTH):0]       fifoCount,
   output logic                         busy,
   output logic                         overflow,
   output logic                         readReq,
   input  logic [DATA_WIDTH-1:0]        readData,
   input  logic                         readValid,
   output logic                         readTimeout,
   input  logic                         clearFlags
);

   localparam int unsigned c_addrWidth  = $clog2(DEPTH);
   localparam int unsigned c_countWidth = $clog2(DEPTH) + 1;
   localparam int unsigned c_entryWidth = CMD_WIDTH + DATA_WIDTH;
   localparam int unsigned c_timerWidth = $clog2(READ_TIMEOUT + 1);

   localparam logic [c_countWidth-1:0] c_fullCount = c_countWidth'(DEPTH);
   localparam logic [c_timerWidth-1:0] c_timerLast = c_timerWidth'(READ_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRIVE = 2'd3
   } readState_t;

   //---------------------------------------------------------------------------
   // Input synchronisers
   //---------------------------------------------------------------------------
   logic r_csSync1, r_csSync2;
   logic r_oeSync1, r_oeSync2;
   logic r_wrSync1, r_wrSync2, r_wrPrev;

   always_ff @(posedge commandClk or negedge resetN) begin
      if (!resetN) begin
         r_csSync1 <= 1'b0;
         r_csSync2 <= 1'b0;
         r_oeSync1 <= 1'b0;
         r_oeSync2 <= 1'b0;
         r_wrSync1 <= 1'b0;
         r_wrSync2 <= 1'b0;
         r_wrPrev  <= 1'b0;
      end else begin
         r_csSync1 <= chipSelect;
         r_csSync2 <= r_csSync1;
         r_oeSync1 <= outputEnable;
         r_oeSync2 <= r_oeSync1;
         r_wrSync1 <= writeStrobe;
         r_wrSync2 <= r_wrSync1;
         r_wrPrev  <= r_wrSync2;
      end
   end

   logic w_writeRise;
   logic w_push;
   logic w_readActive;

   assign w_writeRise  = r_wrSync2 && !r_wrPrev;
   // A write is only meaningful while the host is selecting us and not reading.
   assign w_push       = w_writeRise && r_csSync2 && !r_oeSync2;
   assign w_readActive = r_csSync2 && r_oeSync2;

   //---------------------------------------------------------------------------
   // Command FIFO
   //---------------------------------------------------------------------------
   logic [c_entryWidth-1:0] r_mem [DEPTH];
   logic [c_addrWidth-1:0]  r_wrPtr;
   logic [c_addrWidth-1:0]  r_rdPtr;
   logic [c_countWidth-1:0] r_count;
   logic                    r_overflow;

   logic                    w_full;
   logic                    w_pop;
   logic                    w_pushAccept;
   logic                    w_overflowEvent;
   logic [c_entryWidth-1:0] w_head;

   assign cmdValid        = (r_count != '0);
   assign w_full          = (r_count == c_fullCount);
   assign w_pop           = cmdValid && cmdReady;
   // When full, the slot being vacated by a same-cycle pop is the one the
   // write pointer aims at, so the push can be taken.
   assign w_pushAccept    = w_push && (!w_full || w_pop);
   assign w_overflowEvent = w_push && w_full && !w_pop;

   // Pins are sampled straight away; the host keeps them stable well past
   // the synchronised strobe edge.
   always_ff @(posedge commandClk) begin
      if (w_pushAccept) begin
         r_mem[r_wrPtr] <= {inputCommand, dataIn};
      end
   end

   always_ff @(posedge commandClk or negedge resetN) begin
      if (!resetN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushAccept) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_pushAccept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge commandClk or negedge resetN) begin
      if (!resetN) begin
         r_overflow <= 1'b0;
      end else if (w_overflowEvent) begin
         r_overflow <= 1'b1;
      end else if (clearFlags) begin
         r_overflow <= 1'b0;
      end
   end

   // Head is gated so stale or uninitialised storage never reaches the GPU.
   assign w_head       = r_mem[r_rdPtr];
   assign commandToGpu = cmdValid ? w_head[c_entryWidth-1:DATA_WIDTH] : '0;
   assign dataToGpu    = cmdValid ? w_head[DATA_WIDTH-1:0] : '0;
   assign fifoCount    = r_count;
   assign busy         = w_full;
   assign overflow     = r_overflow;

   //---------------------------------------------------------------------------
   // Read request state machine
   //---------------------------------------------------------------------------
   readState_t              r_state;
   readState_t              w_nextState;
   logic                    r_readActivePrev;
   logic [c_timerWidth-1:0] r_timer;
   logic [DATA_WIDTH-1:0]   r_dataOut;
   logic                    r_dataOutEnable;
   logic                    r_readTimeout;

   logic w_readReq;
   logic w_timerClear;
   logic w_timerInc;
   logic w_loadData;
   logic w_loadOnes;
   logic w_clearOut;

   always_ff @(posedge commandClk or negedge resetN) begin
      if (!resetN) begin
         r_state          <= ST_IDLE;
         r_readActivePrev <= 1'b0;
      end else begin
         r_state          <= w_nextState;
         r_readActivePrev <= w_readActive;
      end
   end

   always_comb begin
      w_nextState  = r_state;
      w_readReq    = 1'b0;
      w_timerClear = 1'b0;
      w_timerInc   = 1'b0;
      w_loadData   = 1'b0;
      w_loadOnes   = 1'b0;
      w_clearOut   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Only a fresh rising edge starts a read; a held-high request
            // after an abort does not retrigger.
            if (w_readActive && !r_readActivePrev) begin
               w_nextState = ST_REQ;
            end
         end
         ST_REQ: begin
            w_readReq    = 1'b1;
            w_timerClear = 1'b1;
            w_nextState  = ST_WAIT;
         end
         ST_WAIT: begin
            if (!w_readActive) begin
               w_nextState = ST_IDLE;
            end else if (readValid) begin
               w_loadData  = 1'b1;
               w_nextState = ST_DRIVE;
            end else if (r_timer == c_timerLast) begin
               w_loadOnes  = 1'b1;
               w_nextState = ST_DRIVE;
            end else begin
               w_timerInc  = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (!w_readActive) begin
               w_clearOut  = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge commandClk or negedge resetN) begin
      if (!resetN) begin
         r_timer         <= '0;
         r_dataOut       <= '0;
         r_dataOutEnable <= 1'b0;
         r_readTimeout   <= 1'b0;
      end else begin
         if (w_timerClear) begin
            r_timer <= '0;
         end else if (w_timerInc) begin
            r_timer <= r_timer + 1'b1;
         end

         if (w_loadData) begin
            r_dataOut <= readData;
         end else if (w_loadOnes) begin
            r_dataOut <= '1;
         end else if (w_clearOut) begin
            r_dataOut <= '0;
         end

         // Registered from next state so the pad enable is glitch-free and
         // lines up exactly with the DRIVE state.
         r_dataOutEnable <= (w_nextState == ST_DRIVE);

         if (w_loadOnes) begin
            r_readTimeout <= 1'b1;
         end else if (clearFlags) begin
            r_readTimeout <= 1'b0;
         end
      end
   end

   assign readReq       = w_readReq;
   assign dataOut       = r_dataOut;
   assign dataOutEnable = r_dataOutEnable;
   assign readTimeout   = r_readTimeout;

endmodule
`default_nettype wire

// File: tb/tb_command_fifo_interface.sv
`timescale 1ns/1ps
`default_nettype none
//=============================================================================
// Module   : tb_command_fifo_interface
// Purpose  : Self-checking bench for command_fifo_interface. Host writes are
//            tracked by a queue model of the FIFO; reads are checked against
//            the expected request/response timing.
// Revision : 1.0 - initial release
//=============================================================================
module tb_command_fifo_interface;

   localparam int CW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int RT    = 8;

   logic          commandClk   = 1'b0;
   logic          resetN       = 1'b0;
   logic          chipSelect   = 1'b0;
   logic          outputEnable = 1'b0;
   logic          writeStrobe  = 1'b0;
   logic [CW-1:0] inputCommand = '0;
   logic [DW-1:0] dataIn       = '0;
   logic [DW-1:0] dataOut;
   logic          dataOutEnable;
   logic [CW-1:0] commandToGpu;
   logic [DW-1:0] dataToGpu;
   logic          cmdValid;
   logic          cmdReady     = 1'b0;
   logic [3:0]    fifoCount;
   logic          busy;
   logic          overflow;
   logic          readReq;
   logic [DW-1:0] readData     = '0;
   logic          readValid    = 1'b0;
   logic          readTimeout;
   logic          clearFlags   = 1'b0;

   command_fifo_interface #(
      .CMD_WIDTH(CW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_TIMEOUT(RT)
   ) dut (
      .commandClk(commandClk), .resetN(resetN),
      .chipSelect(chipSelect), .outputEnable(outputEnable), .writeStrobe(writeStrobe),
      .inputCommand(inputCommand), .dataIn(dataIn),
      .dataOut(dataOut), .dataOutEnable(dataOutEnable),
      .commandToGpu(commandToGpu), .dataToGpu(dataToGpu),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .fifoCount(fifoCount), .busy(busy), .overflow(overflow),
      .readReq(readReq), .readData(readData), .readValid(readValid),
      .readTimeout(readTimeout), .clearFlags(clearFlags)
   );

   always #5 commandClk = ~commandClk;

   int total = 0;
   int bad   = 0;

   // FIFO reference: entries are {command, data}
   logic [CW+DW-1:0] mq[$];
   bit               mOvf = 1'b0;
   int               reqSeen = 0;

   always @(negedge commandClk) begin
      if (readReq === 1'b1) reqSeen++;
   end

   // Advance one clock, updating the queue model. Called at a negedge.
   task automatic step(input bit doPush, input bit rdy);
      bit popNow, fullNow, ovfEv;
      cmdReady = rdy;
      popNow   = (mq.size() != 0) && rdy;
      fullNow  = (mq.size() == DEPTH);
      ovfEv    = 1'b0;
      @(posedge commandClk);
      if (popNow) mq.delete(0);
      if (doPush) begin
         if (!fullNow || popNow) mq.push_back({inputCommand, dataIn});
         else ovfEv = 1'b1;
      end
      if (ovfEv) mOvf = 1'b1;
      else if (clearFlags) mOvf = 1'b0;
      @(negedge commandClk);
   endtask

   // One host write strobe. The write lands on the third edge after the
   // strobe rises. readyMode: 0 never ready, 1 random ready, 2 ready only
   // on the push edge.
   task automatic host_write(input logic [CW-1:0] c, input logic [DW-1:0] d,
                             input bit cs, input int readyMode);
      chipSelect   = cs;
      outputEnable = 1'b0;
      inputCommand = c;
      dataIn       = d;
      writeStrobe  = 1'b1;
      step(1'b0, (readyMode == 1) && ($urandom_range(3, 0) == 0));
      step(1'b0, (readyMode == 1) && ($urandom_range(3, 0) == 0));
      step(cs,   (readyMode == 2) || ((readyMode == 1) && ($urandom_range(3, 0) == 0)));
      step(1'b0, (readyMode == 1) && ($urandom_range(3, 0) == 0));
      writeStrobe = 1'b0;
      repeat (3) step(1'b0, (readyMode == 1) && ($urandom_range(3, 0) == 0));
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chipSelect   = 1'($urandom);
         outputEnable = 1'($urandom);
         writeStrobe  = 1'($urandom);
         inputCommand = 16'($urandom);
         dataIn       = 16'($urandom);
         cmdReady     = 1'($urandom);
         readValid    = 1'($urandom);
         readData     = 16'($urandom);
         @(negedge commandClk);
         total++;
         if ({cmdValid, fifoCount, busy, overflow, readReq, readTimeout, dataOutEnable,
              dataOut, commandToGpu, dataToGpu} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got cv=%b cnt=%0d busy=%b ovf=%b req=%b to=%b oe=%b do=%h cmd=%h dat=%h required all 0",
                     cmdValid, fifoCount, busy, overflow, readReq, readTimeout, dataOutEnable,
                     dataOut, commandToGpu, dataToGpu);
         end
      end
      chipSelect = 1'b1; outputEnable = 1'b0; writeStrobe = 1'b0;
      cmdReady = 1'b0; readValid = 1'b0; clearFlags = 1'b0;
      mq.delete(); mOvf = 1'b0;
      resetN = 1'b1;
      repeat (5) step(1'b0, 1'b0);
      total++;
      if ({cmdValid, fifoCount, dataOutEnable, readReq, overflow} !== '0) begin
         bad++;
         $display("FAIL reset_release: got cv=%b cnt=%0d oe=%b req=%b ovf=%b required all 0",
                  cmdValid, fifoCount, dataOutEnable, readReq, overflow);
      end
   endtask

   task automatic test_single_write();
      chipSelect = 1'b1; outputEnable = 1'b0;
      inputCommand = 16'h00A5; dataIn = 16'h1234; writeStrobe = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      total++;
      if (cmdValid !== 1'b0) begin
         bad++; $display("FAIL write_latency_early: cmdValid=%b required 0", cmdValid);
      end
      step(1'b1, 1'b0);
      total++;
      if (cmdValid !== 1'b1) begin
         bad++; $display("FAIL write_latency: cmdValid=%b required 1", cmdValid);
      end
      total++;
      if ({commandToGpu, dataToGpu} !== 32'h00A5_1234) begin
         bad++; $display("FAIL single_head: got %h/%h required 00a5/1234", commandToGpu, dataToGpu);
      end
      step(1'b0, 1'b0);
      writeStrobe = 1'b0;
      repeat (3) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      cmdReady = 1'b0;
      total++;
      if (cmdValid !== 1'b0 || fifoCount !== 4'd0) begin
         bad++; $display("FAIL single_pop: cmdValid=%b count=%0d required 0/0", cmdValid, fifoCount);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i <= DEPTH; i++) begin
         host_write(16'($urandom), 16'(i), 1'b1, 0);
         if (i == DEPTH - 2) begin
            total++;
            if (busy !== 1'b0) begin
               bad++; $display("FAIL busy_before_full: busy=%b required 0", busy);
            end
         end
         if (i == DEPTH - 1) begin
            total++;
            if (busy !== 1'b1 || int'(fifoCount) !== DEPTH) begin
               bad++; $display("FAIL busy_full: busy=%b count=%0d required 1/%0d", busy, fifoCount, DEPTH);
            end
         end
      end
      total++;
      if (overflow !== 1'b1 || int'(fifoCount) !== DEPTH) begin
         bad++; $display("FAIL overflow_set: ovf=%b count=%0d required 1/%0d", overflow, fifoCount, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (dataToGpu !== 16'(i) || commandToGpu !== mq[0][CW+DW-1:DW]) begin
            bad++; $display("FAIL drain_order[%0d]: got %h/%h required %h/%h",
                            i, commandToGpu, dataToGpu, mq[0][CW+DW-1:DW], 16'(i));
         end
         step(1'b0, 1'b1);
      end
      cmdReady = 1'b0;
      total++;
      if (cmdValid !== 1'b0 || overflow !== 1'b1) begin
         bad++; $display("FAIL drain_empty: cmdValid=%b ovf=%b required 0/1", cmdValid, overflow);
      end
      clearFlags = 1'b1;
      step(1'b0, 1'b0);
      clearFlags = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++; $display("FAIL overflow_clear: ovf=%b required 0", overflow);
      end
   endtask

   task automatic test_push_pop_full();
      for (int i = 0; i < DEPTH; i++) host_write(16'($urandom), 16'(i), 1'b1, 0);
      host_write(16'($urandom), 16'(DEPTH), 1'b1, 2);
      total++;
      if (int'(fifoCount) !== DEPTH || overflow !== 1'b0) begin
         bad++; $display("FAIL full_push_pop: count=%0d ovf=%b required %0d/0", fifoCount, overflow, DEPTH);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         total++;
         if (dataToGpu !== 16'(i)) begin
            bad++; $display("FAIL full_drain[%0d]: got %h required %h", i, dataToGpu, 16'(i));
         end
         step(1'b0, 1'b1);
      end
      cmdReady = 1'b0;
   endtask

   task automatic test_random_traffic();
      for (int n = 0; n < 25; n++) begin
         host_write(16'($urandom), 16'($urandom), ($urandom_range(4, 0) != 0), 1);
         total++;
         if (cmdValid !== (mq.size() != 0) || int'(fifoCount) !== mq.size() ||
             busy !== (mq.size() == DEPTH) || overflow !== mOvf) begin
            bad++; $display("FAIL rand_state[%0d]: cv=%b cnt=%0d busy=%b ovf=%b required cnt=%0d ovf=%b",
                            n, cmdValid, fifoCount, busy, overflow, mq.size(), mOvf);
         end
         if (mq.size() != 0) begin
            total++;
            if ({commandToGpu, dataToGpu} !== mq[0]) begin
               bad++; $display("FAIL rand_head[%0d]: got %h%h required %h", n, commandToGpu, dataToGpu, mq[0]);
            end
         end
      end
      for (int g = 0; g < 2 * DEPTH && mq.size() != 0; g++) step(1'b0, 1'b1);
      clearFlags = 1'b1;
      step(1'b0, 1'b0);
      clearFlags = 1'b0;
      total++;
      if (cmdValid !== 1'b0 || overflow !== 1'b0 || mq.size() != 0) begin
         bad++; $display("FAIL rand_drain: cv=%b ovf=%b modelSize=%0d required 0/0/0", cmdValid, overflow, mq.size());
      end
   endtask

   task automatic test_read();
      logic [DW-1:0] val;
      int k, waitN;
      for (int it = 0; it < 3; it++) begin
         val = (it == 0) ? 16'hBEEF : 16'($urandom);
         k   = (it == 0) ? 5 : int'($urandom_range(6, 1));
         reqSeen = 0;
         chipSelect = 1'b1; outputEnable = 1'b1;
         waitN = 0;
         while (readReq !== 1'b1 && waitN < 10) begin
            @(negedge commandClk); waitN++;
         end
         total++;
         if (waitN != 3) begin
            bad++; $display("FAIL read_req_latency[%0d]: got %0d cycles required 3", it, waitN);
         end
         repeat (k) @(negedge commandClk);
         total++;
         if (dataOutEnable !== 1'b0) begin
            bad++; $display("FAIL read_early_drive[%0d]: oe=%b required 0", it, dataOutEnable);
         end
         readValid = 1'b1; readData = val;
         @(negedge commandClk);
         readValid = 1'b0; readData = 16'($urandom);
         total++;
         if (dataOutEnable !== 1'b1 || dataOut !== val) begin
            bad++; $display("FAIL read_data[%0d]: oe=%b data=%h required 1/%h", it, dataOutEnable, dataOut, val);
         end
         repeat (3) @(negedge commandClk);
         total++;
         if (dataOutEnable !== 1'b1 || dataOut !== val || reqSeen != 1) begin
            bad++; $display("FAIL read_hold[%0d]: oe=%b data=%h reqs=%0d required 1/%h/1",
                            it, dataOutEnable, dataOut, reqSeen, val);
         end
         outputEnable = 1'b0;
         @(negedge commandClk);
         total++;
         if (dataOutEnable !== 1'b1) begin
            bad++; $display("FAIL read_release_early[%0d]: oe=%b required 1", it, dataOutEnable);
         end
         repeat (2) @(negedge commandClk);
         total++;
         if (dataOutEnable !== 1'b0 || dataOut !== '0) begin
            bad++; $display("FAIL read_release[%0d]: oe=%b data=%h required 0/0", it, dataOutEnable, dataOut);
         end
      end
   endtask

   task automatic test_timeout();
      int waitN;
      chipSelect = 1'b1; outputEnable = 1'b1;
      waitN = 0;
      while (readReq !== 1'b1 && waitN < 10) begin
         @(negedge commandClk); waitN++;
      end
      total++;
      if (waitN >= 10) begin
         bad++; $display("FAIL timeout_req: no readReq within 10 cycles, required one");
      end
      repeat (RT) @(negedge commandClk);
      total++;
      if (dataOutEnable !== 1'b0 || readTimeout !== 1'b0) begin
         bad++; $display("FAIL timeout_early: oe=%b to=%b required 0/0", dataOutEnable, readTimeout);
      end
      @(negedge commandClk);
      total++;
      if (dataOutEnable !== 1'b1 || dataOut !== 16'hFFFF || readTimeout !== 1'b1) begin
         bad++; $display("FAIL timeout_fire: oe=%b data=%h to=%b required 1/ffff/1", dataOutEnable, dataOut, readTimeout);
      end
      clearFlags = 1'b1;
      @(negedge commandClk);
      clearFlags = 1'b0;
      total++;
      if (readTimeout !== 1'b0) begin
         bad++; $display("FAIL timeout_clear: to=%b required 0", readTimeout);
      end
      outputEnable = 1'b0;
      repeat (4) @(negedge commandClk);
      total++;
      if (dataOutEnable !== 1'b0) begin
         bad++; $display("FAIL timeout_release: oe=%b required 0", dataOutEnable);
      end
   endtask

   task automatic test_abort();
      int  waitN;
      bit  sawDrive;
      reqSeen  = 0;
      sawDrive = 1'b0;
      chipSelect = 1'b1; outputEnable = 1'b1;
      waitN = 0;
      while (readReq !== 1'b1 && waitN < 10) begin
         @(negedge commandClk); waitN++;
      end
      repeat (2) begin
         @(negedge commandClk); sawDrive |= dataOutEnable;
      end
      outputEnable = 1'b0;
      repeat (4) begin
         @(negedge commandClk); sawDrive |= dataOutEnable;
      end
      readValid = 1'b1; readData = 16'($urandom);
      @(negedge commandClk);
      readValid = 1'b0;
      repeat (RT + 4) begin
         sawDrive |= dataOutEnable;
         @(negedge commandClk);
      end
      total++;
      if (sawDrive || readTimeout !== 1'b0 || reqSeen != 1 || dataOut !== '0) begin
         bad++; $display("FAIL abort: drove=%b to=%b reqs=%0d data=%h required 0/0/1/0",
                         sawDrive, readTimeout, reqSeen, dataOut);
      end
   endtask

   task automatic test_reset_midflight();
      int waitN;
      host_write(16'($urandom), 16'($urandom), 1'b1, 0);
      host_write(16'($urandom), 16'($urandom), 1'b1, 0);
      chipSelect = 1'b1; outputEnable = 1'b1;
      waitN = 0;
      while (readReq !== 1'b1 && waitN < 10) begin
         @(negedge commandClk); waitN++;
      end
      #1 resetN = 1'b0;
      #1;
      total++;
      if (readReq !== 1'b0 || cmdValid !== 1'b0 || fifoCount !== 4'd0 || dataOutEnable !== 1'b0) begin
         bad++; $display("FAIL reset_mid: req=%b cv=%b cnt=%0d oe=%b required 0/0/0/0",
                         readReq, cmdValid, fifoCount, dataOutEnable);
      end
      mq.delete(); mOvf = 1'b0;
      outputEnable = 1'b0;
      @(negedge commandClk);
      resetN = 1'b1;
      repeat (4) step(1'b0, 1'b0);
      total++;
      if (cmdValid !== 1'b0 || readReq !== 1'b0) begin
         bad++; $display("FAIL reset_mid_release: cv=%b req=%b required 0/0", cmdValid, readReq);
      end
   endtask

   initial begin
      @(negedge commandClk);
      test_reset();
      test_single_write();
      test_fill_overflow();
      test_push_pop_full();
      test_random_traffic();
      test_read();
      test_timeout();
      test_abort();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
